stage_id_hc: RTL and testbench
==============================

# stage_id_hc

Parametrised instruction-decode stage with pipeline control. Decodes the fetched instruction, reads the register file and registers all operands and control signals into the ID/EX pipeline register. Unlike the first-generation decode stage, it carries a valid bit and honours downstream stall and branch flush. It detects load-use hazards against the instruction it holds, inserting a bubble and requesting IF to hold. Sits between the fetch stage and the execute stage.

## Interface
Parameters:
- DATA_DBUS_WIDTH, 32, data path / register width
- DATA_IBUS_WIDTH, 32, instruction width (decode fields fixed at bits 31:0)
- ADDR_IBUS_WIDTH, 32, PC width
- REG_WIDTH, 5, register index width; register file has 2**REG_WIDTH entries, entry 0 reads as zero

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_Inst  in  DATA_IBUS_WIDTH  instruction from IF
- i_InstValid  in  1  i_Inst/i_PCPlus4 carry a real instruction
- i_PCPlus4  in  ADDR_IBUS_WIDTH  PC of next instruction
- i_RegToWrite  in  REG_WIDTH  writeback register index
- i_RegWriteData  in  DATA_DBUS_WIDTH  writeback data
- i_RegWriteEnable  in  1  writeback enable
- i_Stall  in  1  downstream stall: hold ID/EX register
- i_Flush  in  1  branch taken: squash the instruction being decoded
- o_Hazard  out  1  load-use hazard; IF must hold PC and IF/ID
- o_Valid  out  1  ID/EX holds a real instruction
- o_DataA, o_DataB  out  DATA_DBUS_WIDTH  operands for RS, RT
- o_InstRS, o_InstRT, o_InstRD  out  REG_WIDTH  register fields
- o_InstIMM  out  DATA_DBUS_WIDTH  sign-extended i_Inst[15:0]
- o_RegWriteEnable, o_MemWriteEnable, o_RegDst, o_MemToReg, o_AluSrcB, o_BranchRequest  out  1  controller outputs
- o_AluControl  out  3  ALU operation
- o_PCPlus4  out  ADDR_IBUS_WIDTH  forwarded PC

## Operation
- Decode: RS = i_Inst[25:21], RT = [20:16], RD = [15:11]. IMM sign-extended from bit 15 to DATA_DBUS_WIDTH. Opcode [31:26] and funct [5:0] go to controller.
- Hazard (combinational): hz = o_Valid & o_MemToReg & (o_InstRT != 0) & (o_InstRT == RS | o_InstRT == RT). RT is compared for every opcode (conservative).
- o_Hazard = hz & i_InstValid & ~i_Flush.
- Register update priority per edge:
  - Reset (async, i_rst = 0): all outputs 0.
  - i_Flush = 1: load a bubble.
  - Else i_Stall = 1: hold all outputs unchanged.
  - Else o_Hazard = 1: load a bubble.
  - Else: load decoded fields, operands and controls; o_Valid <= i_InstValid.
- Bubble: o_Valid, o_RegWriteEnable, o_MemWriteEnable, o_MemToReg, o_BranchRequest <= 0. Remaining fields load normally and are don't-care.
- i_InstValid = 0 with no flush or stall: fields load, o_Valid <= 0, all write/branch controls forced 0.
- Register file: writes on the rising edge when i_RegWriteEnable = 1 and i_RegToWrite != 0. Writes to register 0 are ignored.
- A flush takes precedence over a simultaneous stall. The squashed slot is lost regardless of i_Stall.

## Timing
- Decode-to-output latency: 1 cycle.
- o_Hazard is combinational from i_Inst, i_InstValid, i_Flush and the registered outputs. No internal register feeds back to the hazard decision except the ID/EX contents.
- Load-use: exactly one bubble cycle. On the next cycle the load has moved on, so o_Hazard drops and the held instruction issues.
- If i_Stall and hazard coincide, outputs hold and o_Hazard stays high until the stall releases and the bubble is inserted.
- Reset deassertion: first edge loads normally. o_Hazard is 0 while o_Valid = 0.

## Configuration
- STAGE_ID_WB_BYPASS_EN defined: register read is write-through. If i_RegWriteEnable, i_RegToWrite != 0 and i_RegToWrite equals RS (or RT), o_DataA (or o_DataB) loads i_RegWriteData in that same cycle.
- Undefined: register file returns the pre-write value. The execute-stage forwarding must cover the WB-to-ID distance.

## Structure
- Package types: InstOp and InstFn enums, and an AluOp typedef for the 3-bit ALU code. Also a packed struct IdCtrl holding the six 1-bit controls plus AluControl, which is used for the bubble constant ID_CTRL_NOP = all-zero.
- Instantiates the existing controller and regfile. The regfile is parametrised by DATA_DBUS_WIDTH and REG_WIDTH.
- Sub-module: id_hazard_unit, the combinational load-use comparator producing hz.

## Test plan
- Reset: assert i_rst = 0 mid-run with o_Valid = 1 → all outputs 0 immediately, before the clock edge.
- Normal: `add $3,$1,$2` with $1=5 and $2=7 → next cycle o_DataA=5, o_DataB=7, o_InstRD=3, o_RegWriteEnable=1, o_Valid=1.
- Load-use: `lw $4,0($1)` followed by `add $5,$4,$2` → o_Hazard=1 for one cycle; ID/EX gets a bubble (o_Valid=0, o_RegWriteEnable=0); the `add` issues on the following cycle.
- Flush with stall: i_Flush=1 and i_Stall=1 together → o_Valid=0 and o_MemWriteEnable=0 on the next edge.
- Stall: i_Stall=1 for 3 cycles → all outputs unchanged across those cycles.
- Bypass: write $6=0xDEADBEEF while decoding `add $7,$6,$0` → o_DataA=0xDEADBEEF with STAGE_ID_WB_BYPASS_EN defined, the old $6 value without it. A write to $0 has no effect in either build.

Source files
------------

// File: rtl/stage_id_hc_pkg.sv
// Shared decode types for the ID stage: opcode/funct enums, ALU codes and the
// packed control bundle carried into the ID/EX register.
package stage_id_hc_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } InstOp;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } InstFn;

  typedef logic [2:0] AluOp;

  localparam AluOp ALU_AND = 3'b000;
  localparam AluOp ALU_OR  = 3'b001;
  localparam AluOp ALU_ADD = 3'b010;
  localparam AluOp ALU_SUB = 3'b110;
  localparam AluOp ALU_SLT = 3'b111;

  typedef struct packed {
    logic RegWriteEnable;
    logic MemWriteEnable;
    logic RegDst;
    logic MemToReg;
    logic AluSrcB;
    logic BranchRequest;
    AluOp AluControl;
  } IdCtrl;

  localparam IdCtrl ID_CTRL_NOP = IdCtrl'(9'd0);

  // A bubble keeps the datapath selects but must never write or branch.
  function automatic IdCtrl ctrl_bubble(input IdCtrl c);
    IdCtrl b;
    b                = c;
    b.RegWriteEnable = 1'b0;
    b.MemWriteEnable = 1'b0;
    b.MemToReg       = 1'b0;
    b.BranchRequest  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/stage_id_hc_if.sv
// IF/WB/EX-facing bundle of the decode stage. The slave modport is the stage
// itself, the master modport is whoever drives it.
interface stage_id_hc_if #(
  parameter int DATA_DBUS_WIDTH = 32,
  parameter int DATA_IBUS_WIDTH = 32,
  parameter int ADDR_IBUS_WIDTH = 32,
  parameter int REG_WIDTH       = 5
);
  logic [DATA_IBUS_WIDTH-1:0] i_Inst;
  logic                       i_InstValid;
  logic [ADDR_IBUS_WIDTH-1:0] i_PCPlus4;
  logic [REG_WIDTH-1:0]       i_RegToWrite;
  logic [DATA_DBUS_WIDTH-1:0] i_RegWriteData;
  logic                       i_RegWriteEnable;
  logic                       i_Stall;
  logic                       i_Flush;
  logic                       o_Hazard;
  logic                       o_Valid;
  logic [DATA_DBUS_WIDTH-1:0] o_DataA;
  logic [DATA_DBUS_WIDTH-1:0] o_DataB;
  logic [REG_WIDTH-1:0]       o_InstRS;
  logic [REG_WIDTH-1:0]       o_InstRT;
  logic [REG_WIDTH-1:0]       o_InstRD;
  logic [DATA_DBUS_WIDTH-1:0] o_InstIMM;
  logic                       o_RegWriteEnable;
  logic                       o_MemWriteEnable;
  logic                       o_RegDst;
  logic                       o_MemToReg;
  logic                       o_AluSrcB;
  logic                       o_BranchRequest;
  logic [2:0]                 o_AluControl;
  logic [ADDR_IBUS_WIDTH-1:0] o_PCPlus4;

  modport master (
    output i_Inst, i_InstValid, i_PCPlus4, i_RegToWrite, i_RegWriteData,
           i_RegWriteEnable, i_Stall, i_Flush,
    input  o_Hazard, o_Valid, o_DataA, o_DataB, o_InstRS, o_InstRT, o_InstRD,
           o_InstIMM, o_RegWriteEnable, o_MemWriteEnable, o_RegDst, o_MemToReg,
           o_AluSrcB, o_BranchRequest, o_AluControl, o_PCPlus4
  );

  modport slave (
    input  i_Inst, i_InstValid, i_PCPlus4, i_RegToWrite, i_RegWriteData,
           i_RegWriteEnable, i_Stall, i_Flush,
    output o_Hazard, o_Valid, o_DataA, o_DataB, o_InstRS, o_InstRT, o_InstRD,
           o_InstIMM, o_RegWriteEnable, o_MemWriteEnable, o_RegDst, o_MemToReg,
           o_AluSrcB, o_BranchRequest, o_AluControl, o_PCPlus4
  );
endinterface

// File: rtl/stage_id_hc_ctrl.sv
// Main decoder: opcode and funct to the packed control bundle.
module controller import stage_id_hc_pkg::*; (
  input  logic [5:0] i_Op,
  input  logic [5:0] i_Fn,
  output IdCtrl      o_Ctrl
);
  // Unknown opcodes and functs decode as a harmless no-op.
  always_comb begin
    o_Ctrl = ID_CTRL_NOP;
    case (i_Op)
      OP_RTYPE: begin
        o_Ctrl.RegWriteEnable = 1'b1;
        o_Ctrl.RegDst         = 1'b1;
        case (i_Fn)
          FN_ADD:  o_Ctrl.AluControl = ALU_ADD;
          FN_SUB:  o_Ctrl.AluControl = ALU_SUB;
          FN_AND:  o_Ctrl.AluControl = ALU_AND;
          FN_OR:   o_Ctrl.AluControl = ALU_OR;
          FN_SLT:  o_Ctrl.AluControl = ALU_SLT;
          default: o_Ctrl = ID_CTRL_NOP;
        endcase
      end
      OP_LW: begin
        o_Ctrl.RegWriteEnable = 1'b1;
        o_Ctrl.MemToReg       = 1'b1;
        o_Ctrl.AluSrcB        = 1'b1;
        o_Ctrl.AluControl     = ALU_ADD;
      end
      OP_SW: begin
        o_Ctrl.MemWriteEnable = 1'b1;
        o_Ctrl.AluSrcB        = 1'b1;
        o_Ctrl.AluControl     = ALU_ADD;
      end
      OP_BEQ: begin
        o_Ctrl.BranchRequest = 1'b1;
        o_Ctrl.AluControl    = ALU_SUB;
      end
      OP_ADDI: begin
        o_Ctrl.RegWriteEnable = 1'b1;
        o_Ctrl.AluSrcB        = 1'b1;
        o_Ctrl.AluControl     = ALU_ADD;
      end
      default: o_Ctrl = ID_CTRL_NOP;
    endcase
  end
endmodule

// File: rtl/stage_id_hc_hazard.sv
// Load-use comparator: the load sitting in ID/EX targets a source register of
// the instruction now being decoded.
module id_hazard_unit #(
  parameter int REG_WIDTH = 5
) (
  input  logic                 i_Valid,
  input  logic                 i_MemToReg,
  input  logic [REG_WIDTH-1:0] i_ExRT,
  input  logic [REG_WIDTH-1:0] i_RS,
  input  logic [REG_WIDTH-1:0] i_RT,
  output logic                 o_Hz
);
  // RT is compared for every opcode; a false stall is cheaper than a missed one.
  assign o_Hz = i_Valid & i_MemToReg & (i_ExRT != {REG_WIDTH{1'b0}})
              & ((i_ExRT == i_RS) | (i_ExRT == i_RT));
endmodule

// File: rtl/stage_id_hc_regfile.sv
// 2**REG_WIDTH-entry register file, entry 0 hard-wired to zero.
// STAGE_ID_WB_BYPASS_EN makes the read ports write-through.
module regfile #(
  parameter int DATA_DBUS_WIDTH = 32,
  parameter int REG_WIDTH       = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [REG_WIDTH-1:0]       i_RegA,
  input  logic [REG_WIDTH-1:0]       i_RegB,
  input  logic [REG_WIDTH-1:0]       i_RegToWrite,
  input  logic [DATA_DBUS_WIDTH-1:0] i_WriteData,
  input  logic                       i_WriteEnable,
  output logic [DATA_DBUS_WIDTH-1:0] o_DataA,
  output logic [DATA_DBUS_WIDTH-1:0] o_DataB
);
  localparam int NREGS = 2 ** REG_WIDTH;

  logic [DATA_DBUS_WIDTH-1:0] r_regs [NREGS];
  logic                       w_we;

  assign w_we = i_WriteEnable & (i_RegToWrite != {REG_WIDTH{1'b0}});

  // Storage; entry 0 is never written so it keeps its reset zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= {DATA_DBUS_WIDTH{1'b0}};
    end else if (w_we) begin
      r_regs[i_RegToWrite] <= i_WriteData;
    end
  end

  // Read ports.
  always_comb begin
    o_DataA = r_regs[i_RegA];
    o_DataB = r_regs[i_RegB];
`ifdef STAGE_ID_WB_BYPASS_EN
    if (w_we && (i_RegToWrite == i_RegA)) o_DataA = i_WriteData;
    else                                  o_DataA = r_regs[i_RegA];
    if (w_we && (i_RegToWrite == i_RegB)) o_DataB = i_WriteData;
    else                                  o_DataB = r_regs[i_RegB];
`endif
  end
endmodule

// File: rtl/stage_id_hc.sv
// Decode stage with valid bit, stall/flush and load-use bubble insertion.
// Optional STAGE_ID_WB_BYPASS_EN (in the regfile) gives write-through reads.
module stage_id_hc import stage_id_hc_pkg::*; #(
  parameter int DATA_DBUS_WIDTH = 32,
  parameter int DATA_IBUS_WIDTH = 32,
  parameter int ADDR_IBUS_WIDTH = 32,
  parameter int REG_WIDTH       = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  stage_id_hc_if.slave  bus
);
  logic [DATA_IBUS_WIDTH-1:0] w_inst;
  logic [REG_WIDTH-1:0]       w_rs, w_rt, w_rd;
  logic [DATA_DBUS_WIDTH-1:0] w_imm, w_rf_a, w_rf_b;
  IdCtrl                      w_ctrl;
  logic                       w_hz, w_hazard, w_take, w_load;

  logic                       r_valid;
  logic [DATA_DBUS_WIDTH-1:0] r_data_a, r_data_b, r_imm;
  logic [REG_WIDTH-1:0]       r_rs, r_rt, r_rd;
  logic [ADDR_IBUS_WIDTH-1:0] r_pc;
  IdCtrl                      r_ctrl;

  assign w_inst = bus.i_Inst;
  assign w_rs   = w_inst[21 +: REG_WIDTH];
  assign w_rt   = w_inst[16 +: REG_WIDTH];
  assign w_rd   = w_inst[11 +: REG_WIDTH];
  assign w_imm  = {{(DATA_DBUS_WIDTH-16){w_inst[15]}}, w_inst[15:0]};

  controller u_ctrl (
    .i_Op   (w_inst[31:26]),
    .i_Fn   (w_inst[5:0]),
    .o_Ctrl (w_ctrl)
  );

  regfile #(.DATA_DBUS_WIDTH(DATA_DBUS_WIDTH), .REG_WIDTH(REG_WIDTH)) u_rf (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_RegA        (w_rs),
    .i_RegB        (w_rt),
    .i_RegToWrite  (bus.i_RegToWrite),
    .i_WriteData   (bus.i_RegWriteData),
    .i_WriteEnable (bus.i_RegWriteEnable),
    .o_DataA       (w_rf_a),
    .o_DataB       (w_rf_b)
  );

  id_hazard_unit #(.REG_WIDTH(REG_WIDTH)) u_hz (
    .i_Valid    (r_valid),
    .i_MemToReg (r_ctrl.MemToReg),
    .i_ExRT     (r_rt),
    .i_RS       (w_rs),
    .i_RT       (w_rt),
    .o_Hz       (w_hz)
  );

  assign w_hazard = w_hz & bus.i_InstValid & ~bus.i_Flush;
  // A flush overrides a stall: the squashed slot must become a bubble now.
  assign w_load   = bus.i_Flush | ~bus.i_Stall;
  assign w_take   = bus.i_InstValid & ~bus.i_Flush & ~w_hazard;

  // ID/EX pipeline register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid  <= 1'b0;
      r_data_a <= {DATA_DBUS_WIDTH{1'b0}};
      r_data_b <= {DATA_DBUS_WIDTH{1'b0}};
      r_imm    <= {DATA_DBUS_WIDTH{1'b0}};
      r_rs     <= {REG_WIDTH{1'b0}};
      r_rt     <= {REG_WIDTH{1'b0}};
      r_rd     <= {REG_WIDTH{1'b0}};
      r_pc     <= {ADDR_IBUS_WIDTH{1'b0}};
      r_ctrl   <= ID_CTRL_NOP;
    end else if (w_load) begin
      r_valid  <= w_take;
      r_data_a <= w_rf_a;
      r_data_b <= w_rf_b;
      r_imm    <= w_imm;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_rd     <= w_rd;
      r_pc     <= bus.i_PCPlus4;
      r_ctrl   <= w_take ? w_ctrl : ctrl_bubble(w_ctrl);
    end
  end

  assign bus.o_Hazard         = w_hazard;
  assign bus.o_Valid          = r_valid;
  assign bus.o_DataA          = r_data_a;
  assign bus.o_DataB          = r_data_b;
  assign bus.o_InstRS         = r_rs;
  assign bus.o_InstRT         = r_rt;
  assign bus.o_InstRD         = r_rd;
  assign bus.o_InstIMM        = r_imm;
  assign bus.o_RegWriteEnable = r_ctrl.RegWriteEnable;
  assign bus.o_MemWriteEnable = r_ctrl.MemWriteEnable;
  assign bus.o_RegDst         = r_ctrl.RegDst;
  assign bus.o_MemToReg       = r_ctrl.MemToReg;
  assign bus.o_AluSrcB        = r_ctrl.AluSrcB;
  assign bus.o_BranchRequest  = r_ctrl.BranchRequest;
  assign bus.o_AluControl     = r_ctrl.AluControl;
  assign bus.o_PCPlus4        = r_pc;
endmodule

// File: tb/tb_stage_id_hc.sv
// Directed bench for stage_id_hc: an instruction-level model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_stage_id_hc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] pc = 32'h0000_1000;

  stage_id_hc_if bus ();

  stage_id_hc dut (.i_clk(clk), .i_rst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model state: {rwe,mwe,regdst,m2r,alusrc,br,alu[2:0]}
  logic        m_valid = 1'b0;
  logic [8:0]  m_ctrl = 9'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_imm = 32'd0, m_pc = 32'd0;
  logic [4:0]  m_rs = 5'd0, m_rt = 5'd0, m_rd = 5'd0;
  logic [31:0] m_rf [32];

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {op, s, t, imm};
  endfunction

  // What each instruction class must drive, written out per mnemonic.
  function automatic logic [8:0] exp_ctrl(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
        6'h20: return 9'b101000_010;
        6'h22: return 9'b101000_110;
        6'h24: return 9'b101000_000;
        6'h25: return 9'b101000_001;
        6'h2A: return 9'b101000_111;
        default: return 9'd0;
      endcase
      6'h23: return 9'b100110_010;
      6'h2B: return 9'b010010_010;
      6'h04: return 9'b000001_110;
      6'h08: return 9'b100010_010;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic model_hazard();
    logic [4:0] rs, rt;
    rs = bus.i_Inst[25:21];
    rt = bus.i_Inst[20:16];
    return m_valid && m_ctrl[5] && (m_rt != 5'd0) && (m_rt == rs || m_rt == rt)
           && bus.i_InstValid && !bus.i_Flush;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update at each active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_ctrl <= 9'd0; m_a <= 32'd0; m_b <= 32'd0;
      m_imm <= 32'd0; m_pc <= 32'd0; m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0;
      for (int k = 0; k < 32; k++) m_rf[k] <= 32'd0;
    end else begin
      logic [4:0] rs, rt, wr;
      logic [31:0] a, b;
      logic ok;
      logic [8:0] c;
      rs = bus.i_Inst[25:21];
      rt = bus.i_Inst[20:16];
      wr = bus.i_RegToWrite;
      if (bus.i_Flush || !bus.i_Stall) begin
        ok = bus.i_InstValid && !bus.i_Flush && !model_hazard();
        c  = exp_ctrl(bus.i_Inst[31:26], bus.i_Inst[5:0]);
        a  = m_rf[rs];
        b  = m_rf[rt];
`ifdef STAGE_ID_WB_BYPASS_EN
        if (bus.i_RegWriteEnable && wr != 5'd0 && wr == rs) a = bus.i_RegWriteData;
        if (bus.i_RegWriteEnable && wr != 5'd0 && wr == rt) b = bus.i_RegWriteData;
`endif
        m_valid <= ok;
        m_ctrl  <= ok ? c : (c & 9'b001010111);
        m_a <= a; m_b <= b; m_rs <= rs; m_rt <= rt; m_rd <= bus.i_Inst[15:11];
        m_imm <= {{16{bus.i_Inst[15]}}, bus.i_Inst[15:0]};
        m_pc  <= bus.i_PCPlus4;
      end
      if (bus.i_RegWriteEnable && wr != 5'd0) m_rf[wr] <= bus.i_RegWriteData;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hazard", {63'd0, bus.o_Hazard}, {63'd0, model_hazard()});
      chk("valid", {63'd0, bus.o_Valid}, {63'd0, m_valid});
      chk("gated_ctrl", {60'd0, bus.o_RegWriteEnable, bus.o_MemWriteEnable, bus.o_MemToReg, bus.o_BranchRequest},
          {60'd0, m_ctrl[8], m_ctrl[7], m_ctrl[5], m_ctrl[3]});
      if (m_valid) begin
        chk("ctrl", {55'd0, bus.o_RegWriteEnable, bus.o_MemWriteEnable, bus.o_RegDst, bus.o_MemToReg,
                     bus.o_AluSrcB, bus.o_BranchRequest, bus.o_AluControl}, {55'd0, m_ctrl});
        chk("operands", {bus.o_DataA, bus.o_DataB}, {m_a, m_b});
        chk("fields", {17'd0, bus.o_InstRS, bus.o_InstRT, bus.o_InstRD, bus.o_PCPlus4},
            {17'd0, m_rs, m_rt, m_rd, m_pc});
        chk("imm", {32'd0, bus.o_InstIMM}, {32'd0, m_imm});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [31:0] inst, input logic v, input logic st, input logic fl);
    bus.i_Inst = inst; bus.i_InstValid = v; bus.i_Stall = st; bus.i_Flush = fl;
    bus.i_PCPlus4 = pc;
    pc = pc + 32'd4;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    bus.i_RegWriteEnable = we; bus.i_RegToWrite = r; bus.i_RegWriteData = d;
  endtask

  initial begin
    logic [31:0] add_dep;
    set_in(32'd0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("reset_valid", {63'd0, bus.o_Valid}, 64'd0);
    chk("reset_data", {bus.o_DataA, bus.o_DataB}, 64'd0);
    chk("reset_rwe", {63'd0, bus.o_RegWriteEnable}, 64'd0);

    set_wb(1'b1, 5'd1, 32'd5); tick();
    set_wb(1'b1, 5'd2, 32'd7); tick();
    set_wb(1'b0, 5'd0, 32'd0);

    set_in(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0); tick();
    chk("add_operands", {bus.o_DataA, bus.o_DataB}, {32'd5, 32'd7});
    chk("add_rd", {59'd0, bus.o_InstRD}, 64'd3);
    chk("add_rwe_valid", {62'd0, bus.o_RegWriteEnable, bus.o_Valid}, 64'd3);

    set_in(itype(6'h23, 1, 4, 16'h0000), 1'b1, 1'b0, 1'b0); tick();
    chk("lw_m2r", {63'd0, bus.o_MemToReg}, 64'd1);
    add_dep = rtype(4, 2, 5, 6'h20);
    set_in(add_dep, 1'b1, 1'b0, 1'b0); #1;
    chk("loaduse_hazard", {63'd0, bus.o_Hazard}, 64'd1);
    tick();
    chk("bubble", {62'd0, bus.o_Valid, bus.o_RegWriteEnable}, 64'd0);
    chk("hazard_drops", {63'd0, bus.o_Hazard}, 64'd0);
    tick();
    chk("add_after_bubble", {58'd0, bus.o_Valid, bus.o_InstRD}, {58'd0, 1'b1, 5'd5});

    set_in(rtype(1, 2, 8, 6'h22), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {58'd0, bus.o_Valid, bus.o_InstRD}, {58'd0, 1'b1, 5'd5});
    end
    bus.i_Stall = 1'b0; tick();
    chk("sub_issue", {29'd0, bus.o_AluControl, bus.o_DataA}, {29'd0, 3'b110, 32'd5});

    set_in(itype(6'h2B, 1, 2, 16'h0004), 1'b1, 1'b1, 1'b1); tick();
    chk("flush_stall", {62'd0, bus.o_Valid, bus.o_MemWriteEnable}, 64'd0);
    set_in(itype(6'h2B, 1, 2, 16'h0004), 1'b1, 1'b0, 1'b0); tick();
    chk("sw", {31'd0, bus.o_MemWriteEnable, bus.o_InstIMM}, {31'd0, 1'b1, 32'd4});
    set_in(itype(6'h04, 1, 2, 16'hFFFE), 1'b1, 1'b0, 1'b0); tick();
    chk("beq_imm", {31'd0, bus.o_BranchRequest, bus.o_InstIMM}, {31'd0, 1'b1, 32'hFFFF_FFFE});

    set_in(itype(6'h23, 1, 9, 16'h0000), 1'b1, 1'b0, 1'b0); tick();
    set_in(rtype(9, 9, 10, 6'h20), 1'b1, 1'b0, 1'b1); #1;
    chk("flush_masks_hazard", {63'd0, bus.o_Hazard}, 64'd0);
    bus.i_Flush = 1'b0; bus.i_Stall = 1'b1; #1;
    chk("stall_hazard", {63'd0, bus.o_Hazard}, 64'd1);
    tick();
    chk("stall_hazard_hold", {61'd0, bus.o_Hazard, bus.o_Valid, bus.o_MemToReg}, 64'd7);
    bus.i_Stall = 1'b0; tick();
    chk("late_bubble", {62'd0, bus.o_Valid, bus.o_Hazard}, 64'd0);
    tick();
    chk("late_issue", {58'd0, bus.o_Valid, bus.o_InstRD}, {58'd0, 1'b1, 5'd10});

    set_in(itype(6'h23, 1, 0, 16'h0000), 1'b1, 1'b0, 1'b0); tick();
    set_in(rtype(0, 0, 11, 6'h20), 1'b1, 1'b0, 1'b0); #1;
    chk("rt0_no_hazard", {63'd0, bus.o_Hazard}, 64'd0);
    tick();

    set_in(itype(6'h23, 1, 4, 16'h0000), 1'b0, 1'b0, 1'b0); tick();
    chk("invalid_inst", {61'd0, bus.o_Valid, bus.o_RegWriteEnable, bus.o_MemToReg}, 64'd0);

    set_in(32'd0, 1'b0, 1'b0, 1'b0); set_wb(1'b1, 5'd6, 32'h1111_1111); tick();
    set_in(rtype(6, 0, 7, 6'h20), 1'b1, 1'b0, 1'b0); set_wb(1'b1, 5'd6, 32'hDEAD_BEEF); tick();
`ifdef STAGE_ID_WB_BYPASS_EN
    chk("bypass_a", {32'd0, bus.o_DataA}, {32'd0, 32'hDEAD_BEEF});
`else
    chk("bypass_a", {32'd0, bus.o_DataA}, {32'd0, 32'h1111_1111});
`endif
    set_in(rtype(6, 0, 7, 6'h20), 1'b1, 1'b0, 1'b0); set_wb(1'b1, 5'd0, 32'h0000_1234); tick();
    chk("r0_write_ignored", {bus.o_DataA, bus.o_DataB}, {32'hDEAD_BEEF, 32'd0});
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(rtype(0, 6, 7, 6'h20), 1'b1, 1'b0, 1'b0); tick();
    chk("r0_reads_zero", {bus.o_DataA, bus.o_DataB}, {32'd0, 32'hDEAD_BEEF});

    rst_n = 1'b0; #1;
    chk("async_reset", {30'd0, bus.o_Valid, bus.o_RegWriteEnable, bus.o_DataB}, 64'd0);
    chk("async_reset_pc", {27'd0, bus.o_InstRD, bus.o_PCPlus4}, 64'd0);
    #4; rst_n = 1'b1;
    set_in(rtype(1, 2, 3, 6'h20), 1'b1, 1'b0, 1'b0); tick();
    chk("after_reset", {31'd0, bus.o_Valid, bus.o_DataA}, {31'd0, 1'b1, 32'd0});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
